// File: rtl/vga_stripe_reader_if.sv
// Read-port bundle between the scan-out reader and the two stripe buffers (port b).
//   pixel_address : read address {x[9:0], y[8:0]}, shared by both buffers
//   mem_bit_0     : 4-bit log-iteration code returned by the stripe-0 buffer
//   mem_bit_1     : 4-bit log-iteration code returned by the stripe-1 buffer
// master = reader side, slave = buffer side.
interface vga_stripe_reader_if;
  logic [18:0] pixel_address;
  logic [3:0]  mem_bit_0;
  logic [3:0]  mem_bit_1;

  modport master (
    output pixel_address,
    input  mem_bit_0,
    input  mem_bit_1
  );

  modport slave (
    input  pixel_address,
    output mem_bit_0,
    output mem_bit_1
  );
endinterface

// File: rtl/vga_stripe_reader.sv
// Scan-out reader for the Julia-set video buffers.
// Generates VGA timing (640x480@60 by default), addresses both stripe buffers through port b,
// picks the stripe that owns the column, maps the 4-bit code to 24-bit RGB and emits a
// one-clock frame_start strobe at the start of vblank.
// Build option: define PALETTE_GRAY_EN for a grey ramp on codes 1..10 instead of red/blue.
// Ports:
//   clock        : pixel clock, also clocks buffer port b
//   reset_n      : asynchronous reset, active low
//   rd           : buffer read bundle (pixel_address out, mem_bit_0/1 in)
//   stripe_done  : pause flags from stripe 0 (bit 0) and stripe 1 (bit 1)
//   vga_r/g/b    : colour channels, zero while blanked
//   vga_hs/vs    : syncs, active low
//   vga_blank_n  : low outside the visible area
//   frame_start  : one-clock pulse when the counters reach (0, V_ACTIVE)
//   all_done     : registered AND of both stripe_done bits
module vga_stripe_reader #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned SPLIT_COL = 321,
  // Buffer port-b read latency in clocks, legal range 1..3.
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  vga_stripe_reader_if.master        rd,
  input  logic [1:0]                 stripe_done,
  output logic [7:0]                 vga_r,
  output logic [7:0]                 vga_g,
  output logic [7:0]                 vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank_n,
  output logic                       frame_start,
  output logic                       all_done
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] SPLIT_C  = 10'(SPLIT_COL);

  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic        active_c, hs_raw, vs_raw, sel_c;
  logic [18:0] addr_q, addr_d;

  // Control delay lines; index RD_LAT lines up with the data returned by the buffers.
  logic [RD_LAT:0] act_dly_q, hs_dly_q, vs_dly_q, sel_dly_q;

  logic [3:0]  code_c;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, vs_q, blank_n_q, all_done_q;

  function automatic logic [23:0] palette(input logic [3:0] code);
    logic [7:0] lvl;
    lvl = 8'(code) * 8'd25;  // max 250, fits in 8 bits
    if (code == 4'd0) begin
      return 24'h000000;
    end else if (code <= 4'd10) begin
`ifdef PALETTE_GRAY_EN
      return {lvl, lvl, lvl};
`else
      return {lvl, 8'h00, 8'hFF - lvl};
`endif
    end else begin
      return 24'hFFFFFF;
    end
  endfunction

  // Raster counters.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    active_c = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    hs_raw   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_raw   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    sel_c    = (h_q >= SPLIT_C);
    addr_d   = active_c ? {h_q, v_q[8:0]} : '0;
  end

  // Stripe 0 owns column SPLIT_COL-1, so the duplicated boundary column comes from it.
  always_comb begin
    code_c = sel_dly_q[RD_LAT] ? rd.mem_bit_1 : rd.mem_bit_0;
    rgb_d  = act_dly_q[RD_LAT] ? palette(code_c) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q        <= '0;
      v_q        <= '0;
      addr_q     <= '0;
      act_dly_q  <= '0;
      hs_dly_q   <= '1;  // deasserted, so no stale sync pulse leaks out after reset
      vs_dly_q   <= '1;
      sel_dly_q  <= '0;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      addr_q     <= addr_d;
      act_dly_q  <= {act_dly_q[RD_LAT-1:0], active_c};
      hs_dly_q   <= {hs_dly_q[RD_LAT-1:0], hs_raw};
      vs_dly_q   <= {vs_dly_q[RD_LAT-1:0], vs_raw};
      sel_dly_q  <= {sel_dly_q[RD_LAT-1:0], sel_c};
      rgb_q      <= rgb_d;
      hs_q       <= hs_dly_q[RD_LAT];
      vs_q       <= vs_dly_q[RD_LAT];
      blank_n_q  <= act_dly_q[RD_LAT];
      all_done_q <= stripe_done[0] & stripe_done[1];
    end
  end

  assign rd.pixel_address = addr_q;
  assign vga_r            = rgb_q[23:16];
  assign vga_g            = rgb_q[15:8];
  assign vga_b            = rgb_q[7:0];
  assign vga_hs           = hs_q;
  assign vga_vs           = vs_q;
  assign vga_blank_n      = blank_n_q;
  assign all_done         = all_done_q;
  // Undelayed: taken straight from the counter state.
  assign frame_start      = (h_q == 10'd0) && (v_q == V_ACT_C);

endmodule

// File: tb/tb_vga_stripe_reader.sv
// Bench for vga_stripe_reader. Full horizontal timing, shortened vertical timing
// (12 visible rows, 18 lines per frame) so that two complete frames stay within budget.
module tb_vga_stripe_reader;

  localparam int LAT     = 3;  // RD_LAT + 2 with RD_LAT = 1
  localparam int H_TOT   = 800;
  localparam int BV_ACT  = 12;
  localparam int BV_FP   = 2;
  localparam int BV_SYNC = 2;
  localparam int BV_BP   = 2;
  localparam int V_TOT   = BV_ACT + BV_FP + BV_SYNC + BV_BP;
  localparam int FRAME   = H_TOT * V_TOT;

`ifdef PALETTE_GRAY_EN
  localparam logic [23:0] C3  = 24'h4B4B4B;
  localparam logic [23:0] C7  = 24'hAFAFAF;
  localparam logic [23:0] C10 = 24'hFAFAFA;
`else
  localparam logic [23:0] C3  = 24'h4B00B4;
  localparam logic [23:0] C7  = 24'hAF0050;
  localparam logic [23:0] C10 = 24'hFA0005;
`endif

  typedef struct {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    int          h;
    int          v;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic [1:0] stripe_done;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, frame_start, all_done;

  vga_stripe_reader_if rd_if ();

  vga_stripe_reader #(
    .V_ACTIVE (BV_ACT),
    .V_FP     (BV_FP),
    .V_SYNC   (BV_SYNC),
    .V_BP     (BV_BP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rd          (rd_if),
    .stripe_done (stripe_done),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start),
    .all_done    (all_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   mode;  // 0: single pixel (5,7)=10, 1: constant 3/7, 2: coordinate pattern
  int   mh, mv, cyc;
  int   cmp_cnt, err_cnt;
  exp_t q[$];

  function automatic logic [3:0] f0(input logic [18:0] a);
    if (mode == 0) return (a == {10'd5, 9'd7}) ? 4'd10 : 4'd0;
    if (mode == 1) return 4'd3;
    return a[12:9];
  endfunction

  function automatic logic [3:0] f1(input logic [18:0] a);
    if (mode == 0) return 4'd0;
    if (mode == 1) return 4'd7;
    return a[3:0] + a[16:13];
  endfunction

  // Buffer model, port b with one clock of read latency.
  always @(posedge clock) begin
    rd_if.mem_bit_0 <= f0(rd_if.pixel_address);
    rd_if.mem_bit_1 <= f1(rd_if.pixel_address);
  end

  function automatic logic [23:0] pal(input logic [3:0] k);
    int l;
    l = 25 * int'(k);
    if (k == 4'd0) return 24'h000000;
    if (k > 4'd10) return 24'hFFFFFF;
`ifdef PALETTE_GRAY_EN
    return {l[7:0], l[7:0], l[7:0]};
`else
    return {l[7:0], 8'h00, 8'(255 - l)};
`endif
  endfunction

  function automatic logic [18:0] addr_of(input int h, input int v);
    logic [9:0] hx;
    logic [8:0] vy;
    hx = 10'(h);
    vy = 9'(v);
    return (h < 640 && v < BV_ACT) ? {hx, vy} : 19'd0;
  endfunction

  function automatic exp_t expect_of(input int h, input int v);
    exp_t       e;
    logic       act;
    logic [3:0] code;
    act     = (h < 640) && (v < BV_ACT);
    code    = (h >= 321) ? f1(addr_of(h, v)) : f0(addr_of(h, v));
    e.rgb   = act ? pal(code) : 24'h0;
    e.hs    = !(h >= 656 && h <= 751);
    e.vs    = !(v >= BV_ACT + BV_FP && v < BV_ACT + BV_FP + BV_SYNC);
    e.blank = act;
    e.h     = h;
    e.v     = v;
    return e;
  endfunction

  function automatic exp_t rst_entry();
    exp_t e;
    e.rgb = 24'h0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0; e.h = -1; e.v = -1;
    return e;
  endfunction

  // Push expectation for the current raster state, then clock once.
  task automatic advance();
    q.push_back(expect_of(mh, mv));
    @(posedge clock);
    #1;
    cyc++;
    mh++;
    if (mh == H_TOT) begin
      mh = 0;
      mv = (mv == V_TOT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic start_run(input int m);
    reset_n = 1'b0;
    mode    = m;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    mh = 0; mv = 0; cyc = 0;
    q.delete();
    repeat (LAT - 1) q.push_back(rst_entry());
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    stripe_done = 2'b11;
    repeat (5) @(posedge clock);
    #1;
    cmp_cnt++; if (vga_hs !== 1'b1) begin err_cnt++; $display("FAIL reset_hs got %b exp 1", vga_hs); end
    cmp_cnt++; if (vga_vs !== 1'b1) begin err_cnt++; $display("FAIL reset_vs got %b exp 1", vga_vs); end
    cmp_cnt++;
    if (vga_blank_n !== 1'b0) begin err_cnt++; $display("FAIL reset_blank got %b exp 0", vga_blank_n); end
    cmp_cnt++;
    if ({vga_r, vga_g, vga_b} !== 24'h0) begin
      err_cnt++; $display("FAIL reset_rgb got %h exp 000000", {vga_r, vga_g, vga_b});
    end
    cmp_cnt++;
    if (rd_if.pixel_address !== 19'd0) begin
      err_cnt++; $display("FAIL reset_addr got %h exp 0", rd_if.pixel_address);
    end
    cmp_cnt++;
    if (frame_start !== 1'b0) begin err_cnt++; $display("FAIL reset_fs got %b exp 0", frame_start); end
    cmp_cnt++;
    if (all_done !== 1'b0) begin err_cnt++; $display("FAIL reset_all_done got %b exp 0", all_done); end
    stripe_done = 2'b00;
  endtask

  task automatic test_latency();
    exp_t       e;
    logic [18:0] ea;
    start_run(0);
    for (int i = 0; i < 7 * H_TOT + 5 + LAT + 4; i++) begin
      ea = addr_of(mh, mv);
      advance();
      cmp_cnt++;
      if (rd_if.pixel_address !== ea) begin
        err_cnt++; $display("FAIL lat_addr cyc %0d got %h exp %h", cyc, rd_if.pixel_address, ea);
      end
      e = q.pop_front();
      cmp_cnt++;
      if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hs !== e.hs || vga_vs !== e.vs ||
          vga_blank_n !== e.blank) begin
        err_cnt++;
        $display("FAIL lat_pix (%0d,%0d) got %h/%b%b%b exp %h/%b%b%b", e.h, e.v,
                 {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, e.rgb, e.hs, e.vs, e.blank);
      end
      if (e.h == 5 && e.v == 7) begin
        cmp_cnt++;
        if ({vga_r, vga_g, vga_b} !== C10 || vga_blank_n !== 1'b1 || cyc != 7 * H_TOT + 5 + LAT) begin
          err_cnt++;
          $display("FAIL lat_5_7 got %h bn=%b cyc=%0d exp %h bn=1 cyc=%0d", {vga_r, vga_g, vga_b},
                   vga_blank_n, cyc, C10, 7 * H_TOT + 5 + LAT);
        end
      end
    end
  endtask

  task automatic test_split();
    exp_t e;
    start_run(1);
    for (int i = 0; i < 660; i++) begin
      advance();
      e = q.pop_front();
      cmp_cnt++;
      if ({vga_r, vga_g, vga_b} !== e.rgb || vga_blank_n !== e.blank) begin
        err_cnt++;
        $display("FAIL split_pix (%0d,%0d) got %h bn=%b exp %h bn=%b", e.h, e.v,
                 {vga_r, vga_g, vga_b}, vga_blank_n, e.rgb, e.blank);
      end
      if (e.v == 0 && (e.h == 320 || e.h == 321 || e.h == 639)) begin
        cmp_cnt++;
        if ({vga_r, vga_g, vga_b} !== ((e.h == 320) ? C3 : C7)) begin
          err_cnt++;
          $display("FAIL split_col%0d got %h exp %h", e.h, {vga_r, vga_g, vga_b},
                   (e.h == 320) ? C3 : C7);
        end
      end
    end
  endtask

  task automatic test_timing();
    exp_t e;
    logic prev_hs, prev_vs;
    int   hs_fall, vs_fall, fs_cnt;
    start_run(2);
    prev_hs = 1'b1; prev_vs = 1'b1;
    hs_fall = -1; vs_fall = -1; fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 900; i++) begin
      advance();
      e = q.pop_front();
      cmp_cnt++;
      if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hs !== e.hs || vga_vs !== e.vs ||
          vga_blank_n !== e.blank) begin
        err_cnt++;
        $display("FAIL tim_pix (%0d,%0d) got %h/%b%b%b exp %h/%b%b%b", e.h, e.v,
                 {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, e.rgb, e.hs, e.vs, e.blank);
      end
      cmp_cnt++;
      if (frame_start !== (mh == 0 && mv == BV_ACT)) begin
        err_cnt++; $display("FAIL tim_fs at (%0d,%0d) got %b", mh, mv, frame_start);
      end
      if (frame_start === 1'b1) fs_cnt++;
      if (prev_hs && !vga_hs) begin
        if (hs_fall >= 0) begin
          cmp_cnt++;
          if (cyc - hs_fall != H_TOT) begin
            err_cnt++; $display("FAIL hs_period got %0d exp %0d", cyc - hs_fall, H_TOT);
          end
        end
        hs_fall = cyc;
      end
      if (!prev_hs && vga_hs) begin
        cmp_cnt++;
        if (cyc - hs_fall != 96) begin err_cnt++; $display("FAIL hs_width got %0d exp 96", cyc - hs_fall); end
      end
      if (prev_vs && !vga_vs) begin
        if (vs_fall >= 0) begin
          cmp_cnt++;
          if (cyc - vs_fall != FRAME) begin
            err_cnt++; $display("FAIL vs_period got %0d exp %0d", cyc - vs_fall, FRAME);
          end
        end
        vs_fall = cyc;
      end
      if (!prev_vs && vga_vs) begin
        cmp_cnt++;
        if (cyc - vs_fall != BV_SYNC * H_TOT) begin
          err_cnt++; $display("FAIL vs_width got %0d exp %0d", cyc - vs_fall, BV_SYNC * H_TOT);
        end
      end
      prev_hs = vga_hs;
      prev_vs = vga_vs;
    end
    cmp_cnt++;
    if (fs_cnt != 2) begin err_cnt++; $display("FAIL fs_count got %0d exp 2", fs_cnt); end
  endtask

  task automatic test_strobes();
    logic [1:0] pats[5] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00};
    logic       ad_q[$];
    logic       prev, exp_ad;
    prev = all_done;
    for (int i = 0; i < 5; i++) begin
      stripe_done = pats[i];
      ad_q.push_back(pats[i][0] & pats[i][1]);
      #1;
      cmp_cnt++;
      if (all_done !== prev) begin
        err_cnt++; $display("FAIL all_done_early pat %b got %b exp %b", pats[i], all_done, prev);
      end
      @(posedge clock);
      #1;
      exp_ad = ad_q.pop_front();
      cmp_cnt++;
      if (all_done !== exp_ad) begin
        err_cnt++; $display("FAIL all_done pat %b got %b exp %b", pats[i], all_done, exp_ad);
      end
      prev = exp_ad;
    end
    stripe_done = 2'b00;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    start_run(1);
    for (int i = 0; i < FRAME; i++) begin
      if (mh == 700 && mv == 9) break;
      advance();
      e = q.pop_front();
      cmp_cnt++;
      if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hs !== e.hs || vga_blank_n !== e.blank) begin
        err_cnt++;
        $display("FAIL mid_pre (%0d,%0d) got %h/%b%b exp %h/%b%b", e.h, e.v,
                 {vga_r, vga_g, vga_b}, vga_hs, vga_blank_n, e.rgb, e.hs, e.blank);
      end
    end
    // hs is mid-pulse here; reset must deassert it at once.
    reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank_n !== 1'b0 || {vga_r, vga_g, vga_b} !== 24'h0 ||
        rd_if.pixel_address !== 19'd0) begin
      err_cnt++;
      $display("FAIL mid_rst got hs=%b vs=%b bn=%b rgb=%h addr=%h exp 1 1 0 000000 0", vga_hs, vga_vs,
               vga_blank_n, {vga_r, vga_g, vga_b}, rd_if.pixel_address);
    end
    start_run(1);
    for (int i = 0; i < 900; i++) begin
      advance();
      e = q.pop_front();
      cmp_cnt++;
      if ({vga_r, vga_g, vga_b} !== e.rgb || vga_hs !== e.hs || vga_vs !== e.vs ||
          vga_blank_n !== e.blank) begin
        err_cnt++;
        $display("FAIL mid_post (%0d,%0d) got %h/%b%b%b exp %h/%b%b%b", e.h, e.v,
                 {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, e.rgb, e.hs, e.vs, e.blank);
      end
      if (cyc == 2) begin
        cmp_cnt++;
        if (rd_if.pixel_address !== 19'd512 || vga_blank_n !== 1'b0) begin
          err_cnt++;
          $display("FAIL mid_restart got addr=%h bn=%b exp 00200 0", rd_if.pixel_address, vga_blank_n);
        end
      end
      if (cyc == LAT) begin
        cmp_cnt++;
        if (vga_blank_n !== 1'b1 || {vga_r, vga_g, vga_b} !== C3) begin
          err_cnt++;
          $display("FAIL mid_first_pix got bn=%b rgb=%h exp 1 %h", vga_blank_n, {vga_r, vga_g, vga_b}, C3);
        end
      end
    end
  endtask

  initial begin
    cmp_cnt     = 0;
    err_cnt     = 0;
    mode        = 0;
    mh          = 0;
    mv          = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    stripe_done = 2'b00;
    test_reset();
    test_latency();
    test_split();
    test_timing();
    test_strobes();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
